branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Parametrised successor to the ID-stage condition checker for the MIPS pipeline.
- Resolves an extended set of branch conditions (signed/unsigned compares) with one registered cycle of latency.
- Keeps a PC-indexed table of 2-bit saturating counters. Fetch reads it combinationally for a prediction; the resolve port updates it and flags mispredicts.
- Sits between the ID/EX boundary (resolve) and the IF stage (predict, flush). Includes saturating statistics counters.

Parameters:
- WORD_LEN, 32, operand width for reg1/reg2.
- PC_LEN, 32, program counter width.
- PHT_DEPTH, 16, number of predictor entries; must be a power of two, ≥2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_pc  in  PC_LEN  fetch PC for lookup.
- f_pred_taken  out  1  combinational prediction for f_pc (counter MSB).
- r_valid  in  1  resolve request this cycle.
- r_stall  in  1  pipeline freeze; blocks capture, PHT update and counters.
- r_pc  in  PC_LEN  PC of the branch being resolved.
- r_cond  in  3  condition code.
- r_reg1, r_reg2  in  WORD_LEN  operands.
- r_pred_taken  in  1  prediction carried down the pipe with this branch.
- br_taken  out  1  registered outcome.
- mispredict  out  1  registered; outcome differs from r_pred_taken.
- out_valid  out  1  registered; a resolve was accepted last cycle.
- stat_branches  out  CNT_W  accepted conditional-branch count.
- stat_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Condition codes:
  - 0 NONE → not taken.
  - 1 JUMP → taken.
  - 2 BEQ → reg1 == reg2.
  - 3 BNE → reg1 != reg2.
  - 4 BLT → signed <.
  - 5 BGE → signed ≥.
  - 6 BLTU → unsigned <.
  - 7 BGEU → unsigned ≥.
- Index: idx = pc[log2(PHT_DEPTH)+1 : 2], dropping the word-offset bits. The same function applies to f_pc and r_pc.
- Accept condition: r_valid && !r_stall.
- On accept, at the next rising edge:
  - out_valid = 1.
  - br_taken = evaluated condition.
  - mispredict = (br_taken_next != r_pred_taken).
- With no accept: out_valid = 0, mispredict = 0, br_taken holds its last value.
- Latency: exactly 1 cycle from accept to out_valid.
- PHT update happens only on accept with cond ∈ {2..7}:
  - taken → counter increments, saturating at 3.
  - not taken → counter decrements, saturating at 0.
  - JUMP and NONE never touch the PHT.
- JUMP still produces mispredict if r_pred_taken = 0. The IF stage uses this to flush.
- NONE with r_pred_taken = 1 produces mispredict = 1 (false-taken recovery).
- Read/write same index in the same cycle: f_pred_taken shows the pre-update value. There is no bypass; the write lands at the edge.
- Stats:
  - stat_branches increments on accept with cond ∈ {2..7}.
  - stat_mispredicts increments on accept where mispredict_next = 1, any cond.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, active-low), taking effect immediately and mid-operation:
  - All PHT entries = 2'b01 (weakly not taken).
  - br_taken = 0, mispredict = 0, out_valid = 0, both stats = 0.
  - f_pred_taken therefore reads 0 during and after reset.
  - A resolve in flight during reset is discarded.

Decomposition:
- Shared package/defines: WORD_LEN, the eight condition-code constants (COND_NONE … COND_BGEU, 3-bit), the PHT reset value, and the counter encodings (SNT=0, WNT=1, WT=2, ST=3).
- The existing 2-bit COND_JUMP/BEQ/BNE defines are superseded by the 3-bit set; the control unit is widened accordingly.
- One natural sub-module: cond_eval. It is purely combinational (cond, reg1, reg2 → taken) and can be tested standalone.
- The PHT and the statistics counters stay in branch_resolver.

Test Plan:
- Reset then idle: f_pc = 0x40 → f_pred_taken = 0; all outputs 0; stats 0.
- Signed vs unsigned compare with reg1 = 0xFFFFFFFF, reg2 = 1, r_pred_taken = 0:
  - BLT → br_taken = 1, mispredict = 1.
  - BLTU → br_taken = 0, mispredict = 0.
  - Each result appears on the cycle after accept.
- Training: four accepted BEQ at r_pc = 0x100 with equal operands → counter goes 1→2→3→3; f_pc = 0x100 reads 1 after the first update edge; stat_branches = 4.
- Stall and aliasing:
  - r_valid = 1 with r_stall = 1 → out_valid = 0; PHT and stats unchanged.
  - r_pc = 0x100 and 0x140 (PHT_DEPTH = 16) share an entry; an update to one is visible at the other.
- Reset mid-operation: assert rst_n = 0 between an accept and its output edge → out_valid stays 0; PHT returns to all-01.
- Saturation: with CNT_W = 4, apply 20 mispredicting JUMPs (r_pred_taken = 0) → stat_mispredicts = 15, stat_branches = 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared constants for the branch resolver
// Purpose: condition-code encodings, 2-bit predictor counter encodings,
//          PHT reset value and the default operand width.
// Ports:   none (package).
package branch_resolver_pkg;

  localparam int WORD_LEN = 32;

  typedef logic [2:0] cond_t;

  localparam cond_t COND_NONE = 3'd0;
  localparam cond_t COND_JUMP = 3'd1;
  localparam cond_t COND_BEQ  = 3'd2;
  localparam cond_t COND_BNE  = 3'd3;
  localparam cond_t COND_BLT  = 3'd4;
  localparam cond_t COND_BGE  = 3'd5;
  localparam cond_t COND_BLTU = 3'd6;
  localparam cond_t COND_BGEU = 3'd7;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  localparam logic [1:0] PHT_RESET = CTR_WNT;

  // Conditional branches (BEQ..BGEU) train the predictor and are counted.
  function automatic logic is_cond_branch(input cond_t c);
    return c >= COND_BEQ;
  endfunction

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// rtl/branch_resolver_cond_eval.sv - combinational branch condition evaluator
// Purpose: decides whether a branch with the given condition code is taken.
// Ports:   cond  - 3-bit condition code
//          reg1  - first operand
//          reg2  - second operand
//          taken - 1 when the condition holds
module cond_eval
  import branch_resolver_pkg::*;
#(
  parameter int WORD_LEN = branch_resolver_pkg::WORD_LEN
) (
  input  logic [2:0]          cond,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic [WORD_LEN-1:0] reg2,
  output logic                taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (reg1 == reg2);
  assign lt_s = ($signed(reg1) < $signed(reg2));
  assign lt_u = (reg1 < reg2);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NONE: taken = 1'b0;
      COND_JUMP: taken = 1'b1;
      COND_BEQ:  taken = eq;
      COND_BNE:  taken = !eq;
      COND_BLT:  taken = lt_s;
      COND_BGE:  taken = !lt_s;
      COND_BLTU: taken = lt_u;
      COND_BGEU: taken = !lt_u;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch resolution, 2-bit PHT predictor and statistics
// Purpose: resolves branch conditions with one registered cycle of latency,
//          trains a PC-indexed table of 2-bit saturating counters and keeps
//          saturating branch / mispredict counters.
// Ports:   clk, rst_n        - clock, asynchronous active-low reset
//          f_pc              - fetch PC for lookup
//          f_pred_taken      - combinational prediction for f_pc
//          r_valid, r_stall  - resolve request / pipeline freeze
//          r_pc, r_cond      - PC and condition of the resolving branch
//          r_reg1, r_reg2    - operands
//          r_pred_taken      - prediction carried with this branch
//          br_taken          - registered outcome
//          mispredict        - registered outcome != carried prediction
//          out_valid         - a resolve was accepted last cycle
//          stat_branches     - accepted conditional-branch count
//          stat_mispredicts  - mispredict count
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int WORD_LEN  = branch_resolver_pkg::WORD_LEN,
  parameter int PC_LEN    = 32,
  parameter int PHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_LEN-1:0]   f_pc,
  output logic                f_pred_taken,
  input  logic                r_valid,
  input  logic                r_stall,
  input  logic [PC_LEN-1:0]   r_pc,
  input  logic [2:0]          r_cond,
  input  logic [WORD_LEN-1:0] r_reg1,
  input  logic [WORD_LEN-1:0] r_reg2,
  input  logic                r_pred_taken,
  output logic                br_taken,
  output logic                mispredict,
  output logic                out_valid,
  output logic [CNT_W-1:0]    stat_branches,
  output logic [CNT_W-1:0]    stat_mispredicts
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]       pht [PHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] r_idx;
  logic             accept;
  logic             taken_next;
  logic             mispredict_next;
  logic             train;
  logic             unused_pc_bits;

  // Word-aligned PCs: the two offset bits carry no information.
  assign f_idx = f_pc[IDX_W+1:2];
  assign r_idx = r_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[PC_LEN-1:IDX_W+2], f_pc[1:0],
                            r_pc[PC_LEN-1:IDX_W+2], r_pc[1:0]};

  // No bypass: a same-cycle update to f_idx becomes visible after the edge.
  assign f_pred_taken = pht[f_idx][1];

  assign accept          = r_valid && !r_stall;
  assign mispredict_next = (taken_next != r_pred_taken);
  assign train           = accept && is_cond_branch(r_cond);

  cond_eval #(.WORD_LEN(WORD_LEN)) u_cond_eval (
    .cond  (r_cond),
    .reg1  (r_reg1),
    .reg2  (r_reg2),
    .taken (taken_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= PHT_RESET;
      end
      br_taken         <= 1'b0;
      mispredict       <= 1'b0;
      out_valid        <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      out_valid  <= accept;
      mispredict <= accept && mispredict_next;
      if (accept) begin
        br_taken <= taken_next;
      end

      if (train) begin
        if (taken_next) begin
          if (pht[r_idx] != CTR_ST) pht[r_idx] <= pht[r_idx] + 2'd1;
        end else begin
          if (pht[r_idx] != CTR_SNT) pht[r_idx] <= pht[r_idx] - 2'd1;
        end
        if (stat_branches != '1) stat_branches <= stat_branches + CNT_W'(1);
      end

      if (accept && mispredict_next && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule
